// File: rtl/avalon_mm_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter with round-robin or fixed priority,
// one outstanding transaction, and a read-timeout watchdog for a silent slave.
module avalon_mm_arbiter #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BE_W       = 4,
  parameter int unsigned RD_TIMEOUT = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              avl_clk_i,
  input  logic              avl_reset_n_i,
  input  logic [ADDR_W-1:0] m0_address_i,
  input  logic [BE_W-1:0]   m0_byteenable_i,
  input  logic              m0_write_i,
  input  logic [DATA_W-1:0] m0_writedata_i,
  input  logic              m0_read_i,
  output logic              m0_waitrequest_o,
  output logic [DATA_W-1:0] m0_readdata_o,
  output logic              m0_readdatavalid_o,
  input  logic [ADDR_W-1:0] m1_address_i,
  input  logic [BE_W-1:0]   m1_byteenable_i,
  input  logic              m1_write_i,
  input  logic [DATA_W-1:0] m1_writedata_i,
  input  logic              m1_read_i,
  output logic              m1_waitrequest_o,
  output logic [DATA_W-1:0] m1_readdata_o,
  output logic              m1_readdatavalid_o,
  output logic [ADDR_W-1:0] s_address_o,
  output logic [BE_W-1:0]   s_byteenable_o,
  output logic              s_write_o,
  output logic              s_read_o,
  output logic [DATA_W-1:0] s_writedata_o,
  input  logic              s_waitrequest_i,
  input  logic [DATA_W-1:0] s_readdata_i,
  input  logic              s_readdatavalid_i,
  output logic [1:0]        grant_o,
  output logic              timeout_err_o
);

  localparam int unsigned CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRdPend} state_e;

  state_e           state_q;
  logic             owner_q;
  logic [1:0]       grant_q;
  logic             last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_err_q;

  logic req0, req1, winner;
  logic own_read, own_write, own_req;
  logic rd_timeout;
  logic [DATA_W-1:0] rd_data;

  assign req0      = m0_read_i | m0_write_i;
  assign req1      = m1_read_i | m1_write_i;
  assign own_read  = owner_q ? m1_read_i : m0_read_i;
  assign own_write = owner_q ? m1_write_i : m0_write_i;
  assign own_req   = own_read | own_write;

  // On a tie the master that did not complete last wins, unless m0 has fixed priority.
  assign winner = (req0 && req1) ? (FIXED_PRIO ? 1'b0 : ~last_q) : req1;

  assign rd_timeout = (state_q == StRdPend) && !s_readdatavalid_i &&
                      (cnt_q == CNT_W'(RD_TIMEOUT - 1));
  assign rd_data    = rd_timeout ? DATA_W'(16'hDEAD) : s_readdata_i;

  assign grant_o       = grant_q;
  assign timeout_err_o = timeout_err_q;

  always_comb begin
    s_address_o        = '0;
    s_byteenable_o     = '0;
    s_write_o          = 1'b0;
    s_read_o           = 1'b0;
    s_writedata_o      = '0;
    m0_waitrequest_o   = 1'b1;
    m1_waitrequest_o   = 1'b1;
    m0_readdata_o      = '0;
    m1_readdata_o      = '0;
    m0_readdatavalid_o = 1'b0;
    m1_readdatavalid_o = 1'b0;
    case (state_q)
      StBusy: begin
        s_address_o    = owner_q ? m1_address_i : m0_address_i;
        s_byteenable_o = owner_q ? m1_byteenable_i : m0_byteenable_i;
        s_writedata_o  = owner_q ? m1_writedata_i : m0_writedata_i;
        s_read_o       = own_read;
        s_write_o      = own_write & ~own_read;
        if (owner_q) m1_waitrequest_o = s_waitrequest_i;
        else         m0_waitrequest_o = s_waitrequest_i;
      end
      StRdPend: begin
        if (owner_q) begin
          m1_readdatavalid_o = s_readdatavalid_i | rd_timeout;
          m1_readdata_o      = rd_data;
        end else begin
          m0_readdatavalid_o = s_readdatavalid_i | rd_timeout;
          m0_readdata_o      = rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge avl_clk_i or negedge avl_reset_n_i) begin
    if (!avl_reset_n_i) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      grant_q       <= 2'b00;
      last_q        <= 1'b1;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            owner_q <= winner;
            grant_q <= winner ? 2'b10 : 2'b01;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (!own_req) begin
            // Master withdrew while stalled: no transfer, pointer untouched.
            state_q <= StIdle;
            grant_q <= 2'b00;
          end else if (!s_waitrequest_i) begin
            if (own_read) begin
              state_q <= StRdPend;
              cnt_q   <= '0;
            end else begin
              state_q <= StIdle;
              grant_q <= 2'b00;
              last_q  <= owner_q;
            end
          end
        end
        StRdPend: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (s_readdatavalid_i || rd_timeout) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= owner_q;
            if (rd_timeout) timeout_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Directed bench for avalon_mm_arbiter: vector table for single transfers and
// stalls, hand sequences for arbitration order, read timeout and mid-read reset.
module tb_avalon_mm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic [15:0] m0_writedata, m1_writedata;
  logic        s_waitrequest, s_readdatavalid;
  logic [15:0] s_readdata;

  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [15:0] m0_readdata, m1_readdata, s_writedata;
  logic [13:0] s_address;
  logic [3:0]  s_byteenable;
  logic        s_write, s_read, timeout_err;
  logic [1:0]  grant;

  logic        f_m0_waitrequest, f_m1_waitrequest, f_m0_readdatavalid, f_m1_readdatavalid;
  logic [15:0] f_m0_readdata, f_m1_readdata, f_s_writedata;
  logic [13:0] f_s_address;
  logic [3:0]  f_s_byteenable;
  logic        f_s_write, f_s_read, f_timeout_err;
  logic [1:0]  f_grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  avalon_mm_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .avl_clk_i(clk), .avl_reset_n_i(rst_n),
    .m0_address_i(m0_address), .m0_byteenable_i(m0_byteenable), .m0_write_i(m0_write),
    .m0_writedata_i(m0_writedata), .m0_read_i(m0_read), .m0_waitrequest_o(m0_waitrequest),
    .m0_readdata_o(m0_readdata), .m0_readdatavalid_o(m0_readdatavalid),
    .m1_address_i(m1_address), .m1_byteenable_i(m1_byteenable), .m1_write_i(m1_write),
    .m1_writedata_i(m1_writedata), .m1_read_i(m1_read), .m1_waitrequest_o(m1_waitrequest),
    .m1_readdata_o(m1_readdata), .m1_readdatavalid_o(m1_readdatavalid),
    .s_address_o(s_address), .s_byteenable_o(s_byteenable), .s_write_o(s_write),
    .s_read_o(s_read), .s_writedata_o(s_writedata), .s_waitrequest_i(s_waitrequest),
    .s_readdata_i(s_readdata), .s_readdatavalid_i(s_readdatavalid),
    .grant_o(grant), .timeout_err_o(timeout_err)
  );

  avalon_mm_arbiter #(.FIXED_PRIO(1'b1)) dut_fixed (
    .avl_clk_i(clk), .avl_reset_n_i(rst_n),
    .m0_address_i(m0_address), .m0_byteenable_i(m0_byteenable), .m0_write_i(m0_write),
    .m0_writedata_i(m0_writedata), .m0_read_i(m0_read), .m0_waitrequest_o(f_m0_waitrequest),
    .m0_readdata_o(f_m0_readdata), .m0_readdatavalid_o(f_m0_readdatavalid),
    .m1_address_i(m1_address), .m1_byteenable_i(m1_byteenable), .m1_write_i(m1_write),
    .m1_writedata_i(m1_writedata), .m1_read_i(m1_read), .m1_waitrequest_o(f_m1_waitrequest),
    .m1_readdata_o(f_m1_readdata), .m1_readdatavalid_o(f_m1_readdatavalid),
    .s_address_o(f_s_address), .s_byteenable_o(f_s_byteenable), .s_write_o(f_s_write),
    .s_read_o(f_s_read), .s_writedata_o(f_s_writedata), .s_waitrequest_i(s_waitrequest),
    .s_readdata_i(s_readdata), .s_readdatavalid_i(s_readdatavalid),
    .grant_o(f_grant), .timeout_err_o(f_timeout_err)
  );

  typedef struct {
    logic m0_wr; logic m0_rd; logic [13:0] m0_addr; logic [15:0] m0_wd;
    logic m1_wr; logic m1_rd; logic [13:0] m1_addr; logic [15:0] m1_wd;
    logic s_wait; logic s_rdv; logic [15:0] s_rdata;
    logic [1:0] e_grant; logic [1:0] e_wait; logic [1:0] e_strb; logic [13:0] e_addr;
    logic [15:0] e_wd; logic [3:0] e_be;
    logic [1:0] e_rdv; logic [15:0] e_m0_rd; logic [15:0] e_m1_rd;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    m0_write = 1'b0; m0_read = 1'b0; m0_address = '0; m0_writedata = '0;
    m1_write = 1'b0; m1_read = 1'b0; m1_address = '0; m1_writedata = '0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  task automatic apply(input vec_t v);
    m0_write = v.m0_wr; m0_read = v.m0_rd; m0_address = v.m0_addr; m0_writedata = v.m0_wd;
    m1_write = v.m1_wr; m1_read = v.m1_rd; m1_address = v.m1_addr; m1_writedata = v.m1_wd;
    s_waitrequest = v.s_wait; s_readdatavalid = v.s_rdv; s_readdata = v.s_rdata;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("vec%0d", i);
    chk({t, ".grant"}, {30'd0, grant}, {30'd0, v.e_grant});
    chk({t, ".wait"}, {30'd0, m1_waitrequest, m0_waitrequest}, {30'd0, v.e_wait});
    chk({t, ".strobe"}, {30'd0, s_write, s_read}, {30'd0, v.e_strb});
    chk({t, ".s_addr"}, {18'd0, s_address}, {18'd0, v.e_addr});
    chk({t, ".s_wdata"}, {16'd0, s_writedata}, {16'd0, v.e_wd});
    chk({t, ".s_be"}, {28'd0, s_byteenable}, {28'd0, v.e_be});
    chk({t, ".rdv"}, {30'd0, m1_readdatavalid, m0_readdatavalid}, {30'd0, v.e_rdv});
    chk({t, ".m0_rdata"}, {16'd0, m0_readdata}, {16'd0, v.e_m0_rd});
    chk({t, ".m1_rdata"}, {16'd0, m1_readdata}, {16'd0, v.e_m1_rd});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Fields: m0{wr,rd,addr,wd} m1{wr,rd,addr,wd} s{wait,rdv,rdata} |
    //         grant wait{m1,m0} strb{wr,rd} s_addr s_wd s_be rdv{m1,m0} m0_rd m1_rd
    tbl[0]  = '{1'b1, 1'b0, 14'd1, 16'h0001, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    tbl[1]  = '{1'b1, 1'b0, 14'd1, 16'h0001, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b01, 2'b10, 2'b10, 14'd1, 16'h0001, 4'hF, 2'b00, 16'h0, 16'h0};
    tbl[2]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    tbl[3]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b1, 14'd3, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    tbl[4]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b1, 14'd3, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b10, 2'b01, 2'b01, 14'd3, 16'h0000, 4'h3, 2'b00, 16'h0, 16'h0};
    tbl[5]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b1, 16'h00A5,
                2'b10, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b10, 16'h0, 16'h00A5};
    // Late readdatavalid while idle must not be forwarded.
    tbl[6]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b1, 16'h1234,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    tbl[7]  = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b0, 14'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    for (int i = 8; i <= 10; i++) begin
      tbl[i] = '{1'b1, 1'b0, 14'd7, 16'h1111, 1'b1, 1'b0, 14'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0,
                 2'b10, 2'b11, 2'b10, 14'd5, 16'hBEEF, 4'h3, 2'b00, 16'h0, 16'h0};
    end
    tbl[11] = '{1'b1, 1'b0, 14'd7, 16'h1111, 1'b1, 1'b0, 14'd5, 16'hBEEF, 1'b0, 1'b0, 16'h0,
                2'b10, 2'b01, 2'b10, 14'd5, 16'hBEEF, 4'h3, 2'b00, 16'h0, 16'h0};
    tbl[12] = '{1'b1, 1'b0, 14'd7, 16'h1111, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    tbl[13] = '{1'b1, 1'b0, 14'd7, 16'h1111, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b01, 2'b10, 2'b10, 14'd7, 16'h1111, 4'hF, 2'b00, 16'h0, 16'h0};
    tbl[14] = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    tbl[15] = '{1'b0, 1'b1, 14'd9, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    tbl[16] = '{1'b0, 1'b1, 14'd9, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b0, 16'h0,
                2'b01, 2'b11, 2'b01, 14'd9, 16'h0000, 4'hF, 2'b00, 16'h0, 16'h0};
    // Owner withdraws its read while stalled.
    tbl[17] = '{1'b0, 1'b0, 14'd9, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b1, 1'b0, 16'h0,
                2'b01, 2'b11, 2'b00, 14'd9, 16'h0000, 4'hF, 2'b00, 16'h0, 16'h0};
    tbl[18] = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    tbl[19] = '{1'b1, 1'b0, 14'd2, 16'h2222, 1'b1, 1'b0, 14'd6, 16'h6666, 1'b0, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};
    // Last completion was m0, so m1 takes the tie.
    tbl[20] = '{1'b1, 1'b0, 14'd2, 16'h2222, 1'b1, 1'b0, 14'd6, 16'h6666, 1'b0, 1'b0, 16'h0,
                2'b10, 2'b01, 2'b10, 14'd6, 16'h6666, 4'h3, 2'b00, 16'h0, 16'h0};
    tbl[21] = '{1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 14'd0, 16'h0000, 1'b0, 1'b0, 16'h0,
                2'b00, 2'b11, 2'b00, 14'd0, 16'h0000, 4'h0, 2'b00, 16'h0, 16'h0};

    m0_byteenable = 4'hF;
    m1_byteenable = 4'h3;
    idle_in();
    repeat (2) @(negedge clk);
    chk("rst.grant", {30'd0, grant}, 32'd0);
    chk("rst.wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
    chk("rst.strobe", {30'd0, s_write, s_read}, 32'd0);
    chk("rst.s_addr", {18'd0, s_address}, 32'd0);
    chk("rst.rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    chk("rst.terr", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check_vec(i, tbl[i]);
    end

    // Both masters request continuously: RR alternates, fixed priority keeps m0.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      m0_write = 1'b1; m0_address = 14'd2; m0_writedata = 16'h2222;
      m1_write = 1'b1; m1_address = 14'd6; m1_writedata = 16'h6666;
      #1;
      chk($sformatf("rr.grant%0d", k), {30'd0, grant},
          (k % 2 == 0) ? 32'd0 : ((k % 4 == 1) ? 32'd1 : 32'd2));
      chk($sformatf("fixed.grant%0d", k), {30'd0, f_grant}, (k % 2 == 0) ? 32'd0 : 32'd1);
    end

    // Read with a silent slave times out after RD_TIMEOUT cycles in read-pending.
    @(negedge clk);
    idle_in();
    m0_read = 1'b1; m0_address = 14'd2;
    #1;
    chk("to.idle_grant", {30'd0, grant}, 32'd0);
    @(negedge clk);
    #1;
    chk("to.busy_grant", {30'd0, grant}, 32'd1);
    chk("to.s_read", {31'd0, s_read}, 32'd1);
    for (int p = 1; p <= 16; p++) begin
      @(negedge clk);
      m0_read = 1'b0;
      #1;
      chk($sformatf("to.m0_rdv%0d", p), {31'd0, m0_readdatavalid}, (p == 16) ? 32'd1 : 32'd0);
      chk($sformatf("to.m1_rdv%0d", p), {31'd0, m1_readdatavalid}, 32'd0);
      chk($sformatf("to.grant%0d", p), {30'd0, grant}, 32'd1);
      chk($sformatf("to.terr%0d", p), {31'd0, timeout_err}, 32'd0);
      if (p == 16) chk("to.rdata", {16'd0, m0_readdata}, 32'h0000DEAD);
    end
    @(negedge clk);
    #1;
    chk("to.after_grant", {30'd0, grant}, 32'd0);
    chk("to.after_terr", {31'd0, timeout_err}, 32'd1);
    chk("to.after_rdv", {31'd0, m0_readdatavalid}, 32'd0);

    // A subsequent m1 read completes normally; the error flag stays set.
    @(negedge clk);
    m1_read = 1'b1; m1_address = 14'd4;
    #1;
    chk("rd1.idle_grant", {30'd0, grant}, 32'd0);
    @(negedge clk);
    #1;
    chk("rd1.grant", {30'd0, grant}, 32'd2);
    chk("rd1.s_read", {31'd0, s_read}, 32'd1);
    chk("rd1.s_addr", {18'd0, s_address}, 32'd4);
    @(negedge clk);
    m1_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 16'h5A5A;
    #1;
    chk("rd1.m1_rdv", {31'd0, m1_readdatavalid}, 32'd1);
    chk("rd1.m1_rdata", {16'd0, m1_readdata}, 32'h00005A5A);
    chk("rd1.m0_rdv", {31'd0, m0_readdatavalid}, 32'd0);
    chk("rd1.terr", {31'd0, timeout_err}, 32'd1);
    @(negedge clk);
    s_readdatavalid = 1'b0;
    #1;
    chk("rd1.end_grant", {30'd0, grant}, 32'd0);
    chk("rd1.end_terr", {31'd0, timeout_err}, 32'd1);

    // Asynchronous reset while a read is pending.
    @(negedge clk);
    m0_read = 1'b1; m0_address = 14'd8;
    @(negedge clk);
    #1;
    chk("rp.busy_grant", {30'd0, grant}, 32'd1);
    @(negedge clk);
    m0_read = 1'b0;
    #1;
    chk("rp.pend_grant", {30'd0, grant}, 32'd1);
    #2;
    rst_n = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 16'h7777;
    #1;
    chk("rp.rst_grant", {30'd0, grant}, 32'd0);
    chk("rp.rst_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
    chk("rp.rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    chk("rp.rst_terr", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    s_readdatavalid = 1'b0;
    rst_n = 1'b1;
    m0_read = 1'b1; m0_address = 14'd8;
    #1;
    chk("rp.post_idle", {30'd0, grant}, 32'd0);
    @(negedge clk);
    #1;
    chk("rp.post_grant", {30'd0, grant}, 32'd1);
    chk("rp.post_s_read", {31'd0, s_read}, 32'd1);
    @(negedge clk);
    m0_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 16'h0C0C;
    #1;
    chk("rp.post_rdv", {31'd0, m0_readdatavalid}, 32'd1);
    chk("rp.post_rdata", {16'd0, m0_readdata}, 32'h00000C0C);
    @(negedge clk);
    idle_in();
    #1;
    chk("rp.end_grant", {30'd0, grant}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
